armleocpu_tlb_assoc: RTL and testbench
======================================

// Module: armleocpu_tlb_assoc
// PURPOSE
//  Parametrised N-way set-associative TLB; successor of the single direct-mapped TLB way.
//  Resolves a 20-bit virtual page number to a 22-bit physical page number plus 8-bit access tag in one cycle.
//  Owns victim selection with a per-set round-robin pointer, so the page-table walker only issues plain writes.
//  Sits between the cache/fetch front-end and the page-table walker.
// PARAMETERS
//  ENTRIES_W  4   log2 sets; set index = virtual_address[ENTRIES_W-1:0]; tag = virtual_address[19:ENTRIES_W]
//  WAYS_W     1   log2 ways (WAYS = 2**WAYS_W); legal range 1..3
//  PHYS_W     22  physical page number width (localparam, fixed)
// PORTS
//  clk                 in   1        clock, all state on posedge
//  rst                 in   1        asynchronous, active-high reset
//  enable              in   1        1 = translate; 0 = bypass (identity map)
//  virtual_address     in   20       VPN to resolve, sampled when resolve=1
//  resolve             in   1        resolve request
//  write               in   1        fill request
//  invalidate          in   1        flush all entries
//  virtual_address_w   in   20       VPN of fill
//  accesstag_w         in   8        fill access tag; bit0 = valid
//  phys_w              in   PHYS_W   fill PPN
//  done                out  1        one-cycle pulse, cycle after an accepted resolve
//  miss                out  1        qualified by done
//  hit_way             out  WAYS_W   hitting way, qualified by done & !miss; 0 otherwise
//  accesstag_r         out  8        {accesstag[7:1], valid} of hitting way; 8'hDF in bypass
//  phys_r              out  PHYS_W   PPN of hitting way; {2'b00, VPN} in bypass
// BEHAVIOUR
//  - Command priority per cycle: resolve > write > invalidate; lower-priority commands in the same cycle are dropped; requester holds until serviced.
//  - Resolve: cycle N registers set index, tag, VPN, enable; in cycle N+1 done=1 and outputs are combinational from the registered request and the arrays.
//    enable_r=1: compare the tag in all ways of the set; hit = valid & tag equal -> miss=0, hit_way, phys_r, accesstag_r from that way; no hit -> miss=1, phys_r/accesstag_r = way 0 contents.
//    enable_r=0: miss=0, hit_way=0, phys_r={2'b00,VPN_r}, accesstag_r=8'b11011111.
//  - Back-to-back resolves allowed every cycle; done may stay high continuously.
//  - Write (accepted cycle N, visible to resolves accepted at N+1 or later):
//    way choice = way in set with valid & matching tag, else lowest-index invalid way, else rr_ptr[set].
//    rr_ptr[set] increments (wraps WAYS-1 -> 0) only when the victim came from rr_ptr.
//    Stores tag, phys_w, accesstag_w[7:1]; valid <= accesstag_w[0] (a write with bit0=0 invalidates that entry).
//    The tag-match rule guarantees at most one hit per set; multi-hit is unreachable.
//  - Resolve at N, write to same set at N+1: the done at N+1 reports pre-write contents.
//  - Invalidate: clears all valid bits and all rr_ptr to 0 in one cycle; tag/phys/accesstag arrays are not cleared.
//  - Reset (async, any time, including mid-resolve): valid=0, rr_ptr=0, access_r=0, enable_r=0, VPN_r=0.
//    Outputs during/after reset: done=0, miss=0, hit_way=0, phys_r=0, accesstag_r=8'hDF.
//  - Data arrays are not reset.
// CONFIGURATION
//  ARMLEOCPU_TLB_STATS_EN defined: adds outputs stat_hits[31:0] and stat_misses[31:0], plus input stat_clear.
//    Counts are taken on done: stat_hits on done & !miss (bypass counts as hit), stat_misses on done & miss.
//    Counters wrap at 2^32, are cleared by rst or stat_clear, and stat_clear wins over a same-cycle increment.
//  Macro undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. rst pulsed, then resolve VPN 0x12345 with enable=1 -> next cycle done=1, miss=1; with enable=0 -> miss=0, phys_r=0x012345, accesstag_r=0xDF.
//  2. Write VPN 0x00010 phys 0x3ABCD tag 0xCF, then resolve 0x00010 -> done=1, miss=0, hit_way=0, phys_r=0x3ABCD, accesstag_r=0xCF.
//  3. WAYS_W=1, ENTRIES_W=4: write VPNs 0x00010, 0x00020, 0x00030 (all set 0) -> third fill replaces way 0 (rr_ptr 0->1); resolve 0x00010 misses; 0x00020 hits way 1; 0x00030 hits way 0.
//  4. Rewrite VPN 0x00020 with phys 0x00055 -> same way 1 overwritten, no rr_ptr advance; resolve returns 0x00055, never two hits.
//  5. Resolve, write and invalidate asserted in the same cycle -> only the resolve acts; entry absent next resolve; invalidate alone then clears all -> every resolve misses.
//  6. rst asserted the cycle after resolve -> done stays 0; with ARMLEOCPU_TLB_STATS_EN, 3 hits + 2 misses give stat_hits=3, stat_misses=2, and stat_clear zeroes both.

Source files
------------

// File: rtl/armleocpu_tlb_assoc_if.sv
// armleocpu_tlb_assoc_if: resolve, fill and flush bundle between requesters and the associative TLB
interface armleocpu_tlb_assoc_if #(
  parameter int WAYS_W = 1
);
  localparam int PHYS_W = 22;
  logic              enable;
  logic [19:0]       virtual_address;
  logic              resolve;
  logic              write;
  logic              invalidate;
  logic [19:0]       virtual_address_w;
  logic [7:0]        accesstag_w;
  logic [PHYS_W-1:0] phys_w;
  logic              done;
  logic              miss;
  logic [WAYS_W-1:0] hit_way;
  logic [7:0]        accesstag_r;
  logic [PHYS_W-1:0] phys_r;
  modport master (
    output enable, virtual_address, resolve, write, invalidate,
           virtual_address_w, accesstag_w, phys_w,
    input  done, miss, hit_way, accesstag_r, phys_r
  );
  modport slave (
    input  enable, virtual_address, resolve, write, invalidate,
           virtual_address_w, accesstag_w, phys_w,
    output done, miss, hit_way, accesstag_r, phys_r
  );
endinterface

// File: rtl/armleocpu_tlb_assoc.sv
// armleocpu_tlb_assoc: N-way set-associative TLB with per-set round-robin victim choice; ARMLEOCPU_TLB_STATS_EN adds hit/miss counters
module armleocpu_tlb_assoc #(
  parameter int ENTRIES_W = 4,
  parameter int WAYS_W = 1
) (
  input  logic clk,
  input  logic rst,
`ifdef ARMLEOCPU_TLB_STATS_EN
  input  logic        stat_clear,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses,
`endif
  armleocpu_tlb_assoc_if.slave bus
);
  localparam int SETS = 2 ** ENTRIES_W;
  localparam int WAYS = 2 ** WAYS_W;
  localparam int TAG_W = 20 - ENTRIES_W;
  localparam int PHYS_W = 22;
  logic [TAG_W-1:0]     tag_a  [SETS][WAYS];
  logic [PHYS_W-1:0]    phys_a [SETS][WAYS];
  logic [6:0]           at_a   [SETS][WAYS];
  logic [WAYS-1:0]      valid  [SETS];
  logic [WAYS_W-1:0]    rr     [SETS];
  logic                 access_r;
  logic                 enable_r;
  logic [19:0]          vpn_r;
  logic [ENTRIES_W-1:0] set_r;
  logic [TAG_W-1:0]     tag_r;
  logic                 hit;
  logic [WAYS_W-1:0]    hway;
  logic [ENTRIES_W-1:0] set_w;
  logic [TAG_W-1:0]     tag_w;
  logic                 m_hit;
  logic [WAYS_W-1:0]    m_way;
  logic                 inv_f;
  logic [WAYS_W-1:0]    inv_way;
  logic [WAYS_W-1:0]    victim;
  logic                 from_rr;
  logic                 do_write;
  logic                 do_inv;
  assign set_r = vpn_r[ENTRIES_W-1:0];
  assign tag_r = vpn_r[19:ENTRIES_W];
  assign set_w = bus.virtual_address_w[ENTRIES_W-1:0];
  assign tag_w = bus.virtual_address_w[19:ENTRIES_W];
  assign do_write = bus.write && !bus.resolve;
  assign do_inv = bus.invalidate && !bus.resolve && !bus.write;
  // lookup of the registered request; a miss leaves hway at 0 so way 0 data is shown
  always_comb begin
    hit = 1'b0;
    hway = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid[set_r][w] && tag_a[set_r][w] == tag_r) begin
        hit = 1'b1;
        hway = WAYS_W'(w);
      end
  end
  assign bus.done = access_r;
  assign bus.miss = access_r && enable_r && !hit;
  assign bus.hit_way = (access_r && enable_r && hit) ? hway : '0;
  assign bus.phys_r = enable_r ? phys_a[set_r][hway] : {2'b00, vpn_r};
  assign bus.accesstag_r = enable_r ? {at_a[set_r][hway], valid[set_r][hway]} : 8'hDF;
  // fill victim: matching entry first, then lowest invalid way, then the round-robin pointer
  always_comb begin
    m_hit = 1'b0;
    m_way = '0;
    inv_f = 1'b0;
    inv_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid[set_w][w] && tag_a[set_w][w] == tag_w) begin
        m_hit = 1'b1;
        m_way = WAYS_W'(w);
      end
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid[set_w][w]) begin
        inv_f = 1'b1;
        inv_way = WAYS_W'(w);
      end
    from_rr = !m_hit && !inv_f;
    victim = m_hit ? m_way : inv_f ? inv_way : rr[set_w];
  end
  // request register, valid bits and round-robin pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      access_r <= 1'b0;
      enable_r <= 1'b0;
      vpn_r <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        rr[s] <= '0;
      end
    end else begin
      access_r <= bus.resolve;
      if (bus.resolve) begin
        enable_r <= bus.enable;
        vpn_r <= bus.virtual_address;
      end
      if (do_write) begin
        valid[set_w][victim] <= bus.accesstag_w[0];
        if (from_rr) rr[set_w] <= rr[set_w] + 1'b1;
      end
      if (do_inv)
        for (int s = 0; s < SETS; s++) begin
          valid[s] <= '0;
          rr[s] <= '0;
        end
    end
  end
  // entry payload arrays keep their contents through reset and invalidate
  always_ff @(posedge clk) begin
    if (do_write) begin
      tag_a[set_w][victim] <= tag_w;
      phys_a[set_w][victim] <= bus.phys_w;
      at_a[set_w][victim] <= bus.accesstag_w[7:1];
    end
  end
`ifdef ARMLEOCPU_TLB_STATS_EN
  // hit/miss counters sampled on done; clear beats a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hits <= '0;
      stat_misses <= '0;
    end else if (stat_clear) begin
      stat_hits <= '0;
      stat_misses <= '0;
    end else if (access_r) begin
      if (bus.miss) stat_misses <= stat_misses + 1'b1;
      else stat_hits <= stat_hits + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_armleocpu_tlb_assoc.sv
// tb_armleocpu_tlb_assoc: scoreboard bench driving directed and random traffic against a reference TLB model
module tb_armleocpu_tlb_assoc;
  localparam int EW = 4;
  localparam int WW = 1;
  localparam int SETS = 2 ** EW;
  localparam int WAYS = 2 ** WW;
  typedef struct {
    bit              miss;
    logic [WW-1:0]   way;
    logic [21:0]     phys;
    logic [7:0]      at;
    bit              chk;
    int              cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t q[$];
  exp_t mon_e;
  bit          m_valid [SETS][WAYS];
  logic [19:0] m_vpn   [SETS][WAYS];
  logic [21:0] m_phys  [SETS][WAYS];
  logic [7:0]  m_at    [SETS][WAYS];
  bit          m_known [SETS][WAYS];
  int          m_rr    [SETS];
  armleocpu_tlb_assoc_if #(.WAYS_W(WW)) bus ();
`ifdef ARMLEOCPU_TLB_STATS_EN
  logic        stat_clear = 1'b0;
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
  int          exp_hits = 0;
  int          exp_misses = 0;
`endif
  armleocpu_tlb_assoc #(.ENTRIES_W(EW), .WAYS_W(WW)) dut (
    .clk(clk),
    .rst(rst),
`ifdef ARMLEOCPU_TLB_STATS_EN
    .stat_clear(stat_clear),
    .stat_hits(stat_hits),
    .stat_misses(stat_misses),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic model_clear_valid();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 0;
    end
  endtask
  function automatic exp_t model_resolve(input bit en, input logic [19:0] va);
    exp_t e;
    int s;
    e.cyc = cyc + 1;
    e.chk = 1;
    e.miss = 0;
    e.way = '0;
    if (!en) begin
      e.phys = {2'b00, va};
      e.at = 8'hDF;
      return e;
    end
    s = int'(va) % SETS;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_vpn[s][w] == va) begin
        e.way = WW'(w);
        e.phys = m_phys[s][w];
        e.at = {m_at[s][w][7:1], 1'b1};
        return e;
      end
    e.miss = 1;
    e.chk = m_known[s][0];
    e.phys = m_phys[s][0];
    e.at = {m_at[s][0][7:1], m_valid[s][0]};
    return e;
  endfunction
  task automatic model_write(input logic [19:0] va, input logic [7:0] at, input logic [21:0] ph);
    int s;
    int v;
    s = int'(va) % SETS;
    v = -1;
    for (int w = 0; w < WAYS; w++)
      if (v < 0 && m_valid[s][w] && m_vpn[s][w] == va) v = w;
    for (int w = 0; w < WAYS; w++)
      if (v < 0 && !m_valid[s][w]) v = w;
    if (v < 0) begin
      v = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % WAYS;
    end
    m_valid[s][v] = at[0];
    m_vpn[s][v] = va;
    m_phys[s][v] = ph;
    m_at[s][v] = at;
    m_known[s][v] = 1;
  endtask
  task automatic cmd(input bit res, input bit en, input logic [19:0] va, input bit wr, input bit inv,
                     input logic [19:0] vaw, input logic [7:0] atw, input logic [21:0] pw);
    exp_t e;
    bus.resolve = res;
    bus.enable = en;
    bus.virtual_address = va;
    bus.write = wr;
    bus.invalidate = inv;
    bus.virtual_address_w = vaw;
    bus.accesstag_w = atw;
    bus.phys_w = pw;
    if (res) begin
      e = model_resolve(en, va);
      q.push_back(e);
`ifdef ARMLEOCPU_TLB_STATS_EN
      if (e.miss) exp_misses++;
      else exp_hits++;
`endif
    end else if (wr) model_write(vaw, atw, pw);
    else if (inv) model_clear_valid();
    @(posedge clk);
    #1;
    bus.resolve = 1'b0;
    bus.write = 1'b0;
    bus.invalidate = 1'b0;
  endtask
  task automatic rd(input bit en, input logic [19:0] va);
    cmd(1, en, va, 0, 0, 20'h0, 8'h0, 22'h0);
  endtask
  task automatic wr(input logic [19:0] va, input logic [21:0] ph, input logic [7:0] at);
    cmd(0, 0, 20'h0, 1, 0, va, at, ph);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_miss"}, 32'(bus.miss), 0);
    check({tag, "_hit_way"}, 32'(bus.hit_way), 0);
    check({tag, "_phys"}, 32'(bus.phys_r), 0);
    check({tag, "_at"}, 32'(bus.accesstag_r), 32'hDF);
  endtask
  function automatic logic [19:0] rva();
    if ($urandom_range(0, 9) == 0) return 20'($urandom);
    return 20'(($urandom_range(0, 3) << EW) | $urandom_range(0, 2));
  endfunction
  always @(negedge clk) begin
    if (!rst) begin
      if (q.size() != 0 && q[0].cyc == cyc) begin
        mon_e = q.pop_front();
        check("done", 32'(bus.done), 1);
        check("miss", 32'(bus.miss), 32'(mon_e.miss));
        check("hit_way", 32'(bus.hit_way), 32'(mon_e.way));
        if (mon_e.chk) begin
          check("phys_r", 32'(bus.phys_r), 32'(mon_e.phys));
          check("accesstag_r", 32'(bus.accesstag_r), 32'(mon_e.at));
        end
      end else if (bus.done) check("spurious_done", 32'(bus.done), 0);
    end
  end
  initial begin
    bus.enable = 1'b0;
    bus.virtual_address = '0;
    bus.resolve = 1'b0;
    bus.write = 1'b0;
    bus.invalidate = 1'b0;
    bus.virtual_address_w = '0;
    bus.accesstag_w = '0;
    bus.phys_w = '0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_known[s][w] = 0;
    model_clear_valid();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    rd(1, 20'h12345);
    rd(0, 20'h12345);
    wr(20'h00010, 22'h3ABCD, 8'hCF);
    rd(1, 20'h00010);
    wr(20'h00020, 22'h00111, 8'h81);
    wr(20'h00030, 22'h00222, 8'h43);
    rd(1, 20'h00010);
    rd(1, 20'h00020);
    rd(1, 20'h00030);
    wr(20'h00020, 22'h00055, 8'hA5);
    rd(1, 20'h00020);
    rd(1, 20'h00030);
    cmd(1, 1, 20'h00020, 1, 1, 20'h00040, 8'h01, 22'h00777);
    rd(1, 20'h00040);
    rd(1, 20'h00020);
    cmd(0, 0, 20'h0, 0, 1, 20'h0, 8'h0, 22'h0);
    rd(1, 20'h00020);
    rd(1, 20'h00030);
    rd(1, 20'h00010);
    wr(20'h00050, 22'h01234, 8'h01);
    wr(20'h00050, 22'h01234, 8'h00);
    rd(1, 20'h00050);
    idle(2);
    bus.resolve = 1'b1;
    bus.enable = 1'b1;
    bus.virtual_address = 20'h00030;
    @(posedge clk);
    #1;
    bus.resolve = 1'b0;
    rst = 1'b1;
    model_clear_valid();
`ifdef ARMLEOCPU_TLB_STATS_EN
    exp_hits = 0;
    exp_misses = 0;
`endif
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    wr(20'h00010, 22'h3ABCD, 8'hCF);
    rd(1, 20'h00010);
    rd(1, 20'h00010);
    rd(0, 20'h00077);
    rd(1, 20'h00070);
    rd(1, 20'h00020);
    idle(2);
`ifdef ARMLEOCPU_TLB_STATS_EN
    check("stat_hits", stat_hits, 32'(exp_hits));
    check("stat_misses", stat_misses, 32'(exp_misses));
    rd(1, 20'h00010);
    stat_clear = 1'b1;
    exp_hits = 0;
    exp_misses = 0;
    idle(1);
    stat_clear = 1'b0;
    idle(1);
    check("stat_hits_clr", stat_hits, 32'(exp_hits));
    check("stat_misses_clr", stat_misses, 32'(exp_misses));
`endif
    for (int i = 0; i < 1500; i++)
      cmd($urandom_range(0, 99) < 45, $urandom_range(0, 9) != 0, rva(),
          $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 3, rva(),
          {7'($urandom), 1'($urandom_range(0, 4) != 0)}, 22'($urandom));
    idle(3);
    check("queue_drained", 32'(q.size()), 0);
`ifdef ARMLEOCPU_TLB_STATS_EN
    check("stat_hits_end", stat_hits, 32'(exp_hits));
    check("stat_misses_end", stat_misses, 32'(exp_misses));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
